vga_score_scheduler: RTL and testbench

VGA_SCORE_SCHEDULER -- requirements
Module: vga_score_scheduler

---
 rtl/vga_score_scheduler.sv | 145 ++++++++++++++
 tb/tb_vga_score_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_score_scheduler.sv
// Six-digit score overlay: buffers a binary score, converts it to BCD and commits it at frame start.
// Optional leading-zero blanking is enabled with `define SCORE_LEADING_ZERO_BLANK_EN.
module vga_score_scheduler #(
    parameter int unsigned ORIGIN_X = 0,
    parameter int unsigned ORIGIN_Y = 0,
    parameter int unsigned DIGIT_W  = 12,
    parameter int unsigned DIGIT_H  = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] score,
    input  logic        update_valid,
    output logic        update_ready,
    input  logic        frame_start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        digit_active,
    output logic [3:0]  digit_value,
    output logic [3:0]  glyph_x,
    output logic [4:0]  glyph_y
);

    // Handshake: a score is taken on any cycle where update_valid and update_ready are both 1;
    // update_ready is 1 only in IDLE and update_valid is otherwise ignored (nothing is queued).
    typedef enum logic [1:0] {IDLE, CONVERT, WAIT_FRAME, COMMIT} state_t;

    localparam logic [31:0] OX      = 32'(ORIGIN_X);
    localparam logic [31:0] OY      = 32'(ORIGIN_Y);
    localparam logic [31:0] FIELD_W = 32'(6 * DIGIT_W);
    localparam logic [31:0] FIELD_H = 32'(DIGIT_H);

    state_t      state, state_next;
    logic [19:0] bin_q;
    logic [23:0] bcd_q;
    logic [23:0] bcd_step;
    logic [4:0]  bit_cnt;
    logic [3:0]  disp [6];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        update_ready = 1'b0;
        case (state)
            IDLE: begin
                update_ready = 1'b1;
                if (update_valid) state_next = CONVERT;
            end
            CONVERT:    if (bit_cnt == 5'd19) state_next = WAIT_FRAME;
            WAIT_FRAME: if (frame_start) state_next = COMMIT;
            COMMIT:     state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Shift-add-3: correct every nibble >= 5 before shifting in the next binary bit.
    always_comb begin
        logic [23:0] adj;
        adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        bcd_step = {adj[22:0], bin_q[19]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            bit_cnt <= '0;
            for (int i = 0; i < 6; i++) disp[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (update_valid) begin
                        bin_q   <= (score > 32'd999999) ? 20'd999999 : score[19:0];
                        bcd_q   <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONVERT: begin
                    bcd_q   <= bcd_step;
                    bin_q   <= {bin_q[18:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                end
                COMMIT: begin
                    for (int i = 0; i < 6; i++) disp[i] <= bcd_q[(5-i)*4 +: 4];
                end
                default: ;
            endcase
        end
    end

    // Pixel path; disp[0] is the most significant digit.
    logic [31:0] dx, dy, cell_base;
    logic [2:0]  k;
    logic        hit;
    logic [5:0]  shown;

    always_comb begin
        dx        = x - OX;
        dy        = y - OY;
        hit       = (x >= OX) && (dx < FIELD_W) && (y >= OY) && (dy < FIELD_H);
        k         = 3'd0;
        cell_base = '0;
        for (int i = 1; i < 6; i++) begin
            if (dx >= 32'(i * DIGIT_W)) begin
                k         = 3'(i);
                cell_base = 32'(i * DIGIT_W);
            end
        end
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic lead;
        lead = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lead     = lead | (disp[i] != 4'd0);
            shown[i] = lead;
        end
        shown[5] = 1'b1;
    end
`else
    assign shown = 6'b111111;
`endif

    always_ff @(posedge clk) begin
        if (reset || !(hit && shown[k])) begin
            digit_active <= 1'b0;
            digit_value  <= '0;
            glyph_x      <= '0;
            glyph_y      <= '0;
        end else begin
            digit_active <= 1'b1;
            digit_value  <= disp[k];
            glyph_x      <= 4'(dx - cell_base);
            glyph_y      <= 5'(dy);
        end
    end

endmodule

// File: tb/tb_vga_score_scheduler.sv
// Directed bench for vga_score_scheduler: handshake timing, BCD commit, saturation, reset abort, cell bounds, blanking.
module tb_vga_score_scheduler;
    localparam int OX = 100;
    localparam int OY = 50;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] score = '0;
    logic        update_valid = 1'b0;
    logic        update_ready;
    logic        frame_start = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        digit_active;
    logic [3:0]  digit_value;
    logic [3:0]  glyph_x;
    logic [4:0]  glyph_y;

    int checks = 0;
    int errors = 0;

    vga_score_scheduler #(.ORIGIN_X(OX), .ORIGIN_Y(OY), .DIGIT_W(12), .DIGIT_H(17)) dut (
        .clk(clk), .reset(reset), .score(score), .update_valid(update_valid),
        .update_ready(update_ready), .frame_start(frame_start), .x(x), .y(y),
        .digit_active(digit_active), .digit_value(digit_value),
        .glyph_x(glyph_x), .glyph_y(glyph_y)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_pixel(input int px, input int py);
        x = 32'(px);
        y = 32'(py);
        step();
    endtask

    task automatic send_update(input logic [31:0] s);
        score = s;
        update_valid = 1'b1;
        step();
        update_valid = 1'b0;
    endtask

    task automatic commit_score(input logic [31:0] s);
        int n;
        send_update(s);
        repeat (20) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n = 0;
        while (!update_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (!update_ready) begin
            errors++;
            $display("FAIL commit_timeout score=%0d: update_ready=%0b required 1", s, update_ready);
        end
    endtask

    function automatic bit exp_on(input logic [23:0] d, input int k);
        if (!BLANK || k == 5) return 1'b1;
        for (int i = 0; i <= k; i++) if (d[(5-i)*4 +: 4] != 4'd0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        x = 32'(OX + 3);
        y = 32'(OY + 2);
        step();
        step();
        checks++;
        if (update_ready !== 1'b1 || digit_active !== 1'b0 || digit_value !== 4'd0 ||
            glyph_x !== 4'd0 || glyph_y !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b act=%0b val=%0d gx=%0d gy=%0d required 1 0 0 0 0",
                     update_ready, digit_active, digit_value, glyph_x, glyph_y);
        end
        reset = 1'b0;
        read_pixel(OX + 3, OY + 2);
        checks++;
        if (digit_active !== exp_on(24'h0, 0) || digit_value !== 4'd0 ||
            glyph_x !== (exp_on(24'h0, 0) ? 4'd3 : 4'd0)) begin
            errors++;
            $display("FAIL reset_cell0: act=%0b val=%0d gx=%0d required act=%0b val=0",
                     digit_active, digit_value, glyph_x, exp_on(24'h0, 0));
        end
    endtask

    task automatic test_basic();
        int low_bad, val_bad;
        logic [23:0] d;
        d = 24'h001234;
        send_update(32'd1234);
        x = 32'(OX + 63);
        y = 32'(OY + 7);
        low_bad = 0;
        val_bad = 0;
        repeat (30) begin
            step();
            if (update_ready !== 1'b0) low_bad++;
            if (digit_value !== 4'd0) val_bad++;
        end
        checks++;
        if (low_bad != 0) begin
            errors++;
            $display("FAIL basic_busy: ready high on %0d of 30 cycles, required 0", low_bad);
        end
        checks++;
        if (val_bad != 0) begin
            errors++;
            $display("FAIL basic_early_display: digit changed on %0d cycles, required 0", val_bad);
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if (update_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_commit_ready: ready=%0b required 0", update_ready);
        end
        step();
        checks++;
        if (update_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle_ready: ready=%0b required 1", update_ready);
        end
        for (int k = 0; k < 6; k++) begin
            read_pixel(OX + k*12 + 3, OY + 7);
            checks++;
            if (digit_active !== exp_on(d, k) ||
                digit_value !== (exp_on(d, k) ? d[(5-k)*4 +: 4] : 4'd0) ||
                glyph_x !== (exp_on(d, k) ? 4'd3 : 4'd0) ||
                glyph_y !== (exp_on(d, k) ? 5'd7 : 5'd0)) begin
                errors++;
                $display("FAIL basic_cell%0d: act=%0b val=%0d gx=%0d gy=%0d required act=%0b val=%0d",
                         k, digit_active, digit_value, glyph_x, glyph_y, exp_on(d, k), d[(5-k)*4 +: 4]);
            end
        end
    endtask

    task automatic test_saturate();
        int low_bad;
        send_update(32'd5000000);
        low_bad = 0;
        repeat (20) begin
            step();
            if (update_ready !== 1'b0) low_bad++;
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        if (update_ready !== 1'b0) low_bad++;
        checks++;
        if (low_bad != 0) begin
            errors++;
            $display("FAIL sat_busy: ready high on %0d cycles, required 0", low_bad);
        end
        step();
        checks++;
        if (update_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_entry_frame: ready=%0b required 1 (frame_start on WAIT_FRAME entry)", update_ready);
        end
        for (int k = 0; k < 6; k++) begin
            read_pixel(OX + k*12, OY);
            checks++;
            if (digit_active !== 1'b1 || digit_value !== 4'd9) begin
                errors++;
                $display("FAIL sat_cell%0d: act=%0b val=%0d required 1 9", k, digit_active, digit_value);
            end
        end
    endtask

    task automatic test_wait_frame();
        int bad;
        logic [23:0] d;
        d = 24'h000042;
        send_update(32'd42);
        repeat (5) step();
        frame_start = 1'b1;
        score = 32'd7;
        update_valid = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        update_valid = 1'b0;
        x = 32'(OX + 60);
        y = 32'(OY + 1);
        bad = 0;
        repeat (100) begin
            step();
            if (update_ready !== 1'b0 || digit_value !== 4'd9) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait_hold: %0d bad cycles (ready high or display changed), required 0", bad);
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        checks++;
        if (update_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready_after_commit: ready=%0b required 1", update_ready);
        end
        for (int k = 0; k < 6; k++) begin
            read_pixel(OX + k*12 + 5, OY + 1);
            checks++;
            if (digit_active !== exp_on(d, k) ||
                digit_value !== (exp_on(d, k) ? d[(5-k)*4 +: 4] : 4'd0)) begin
                errors++;
                $display("FAIL wait_cell%0d: act=%0b val=%0d required act=%0b val=%0d",
                         k, digit_active, digit_value, exp_on(d, k), d[(5-k)*4 +: 4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        send_update(32'd777);
        repeat (10) step();
        reset = 1'b1;
        frame_start = 1'b1;
        update_valid = 1'b1;
        step();
        reset = 1'b0;
        frame_start = 1'b0;
        update_valid = 1'b0;
        checks++;
        if (update_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: ready=%0b required 1", update_ready);
        end
        repeat (25) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 6; k++) begin
            read_pixel(OX + k*12 + 2, OY + 4);
            checks++;
            if (digit_value !== 4'd0 || digit_active !== exp_on(24'h0, k) || update_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_cell%0d: act=%0b val=%0d ready=%0b required act=%0b val=0 ready=1",
                         k, digit_active, digit_value, update_ready, exp_on(24'h0, k));
            end
        end
    endtask

    task automatic test_bounds();
        int mx [4];
        int my [4];
        commit_score(32'd123456);
        mx = '{OX + 72, OX + 5, OX - 1, OX + 5};
        my = '{OY + 7, OY + 17, OY + 7, OY - 1};
        for (int i = 0; i < 4; i++) begin
            read_pixel(mx[i], my[i]);
            checks++;
            if (digit_active !== 1'b0 || digit_value !== 4'd0 || glyph_x !== 4'd0 || glyph_y !== 5'd0) begin
                errors++;
                $display("FAIL bounds_miss%0d: act=%0b val=%0d gx=%0d gy=%0d required all 0",
                         i, digit_active, digit_value, glyph_x, glyph_y);
            end
        end
        read_pixel(OX + 71, OY + 16);
        checks++;
        if (digit_active !== 1'b1 || digit_value !== 4'd6 || glyph_x !== 4'd11 || glyph_y !== 5'd16) begin
            errors++;
            $display("FAIL bounds_last: act=%0b val=%0d gx=%0d gy=%0d required 1 6 11 16",
                     digit_active, digit_value, glyph_x, glyph_y);
        end
        read_pixel(OX + 12, OY);
        checks++;
        if (digit_active !== 1'b1 || digit_value !== 4'd2 || glyph_x !== 4'd0 || glyph_y !== 5'd0) begin
            errors++;
            $display("FAIL bounds_cell1: act=%0b val=%0d gx=%0d gy=%0d required 1 2 0 0",
                     digit_active, digit_value, glyph_x, glyph_y);
        end
        read_pixel(OX + 11, OY + 3);
        checks++;
        if (digit_active !== 1'b1 || digit_value !== 4'd1 || glyph_x !== 4'd11 || glyph_y !== 5'd3) begin
            errors++;
            $display("FAIL bounds_cell0_edge: act=%0b val=%0d gx=%0d gy=%0d required 1 1 11 3",
                     digit_active, digit_value, glyph_x, glyph_y);
        end
    endtask

    task automatic test_zero();
        commit_score(32'd0);
        for (int k = 0; k < 6; k++) begin
            read_pixel(OX + k*12 + 1, OY + 1);
            checks++;
            if (digit_active !== exp_on(24'h0, k) || digit_value !== 4'd0) begin
                errors++;
                $display("FAIL zero_cell%0d: act=%0b val=%0d required act=%0b val=0",
                         k, digit_active, digit_value, exp_on(24'h0, k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_wait_frame();
        test_reset_mid();
        test_bounds();
        test_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
